// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merge, flush, exception redirect sequencing
// and branch-likely delay-slot nullification tracking.
module pipe_ctrl #(
  parameter int AW    = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sreq_if,
  input  logic             sreq_id,
  input  logic             sreq_ex,
  input  logic             sreq_mem,
  input  logic             exc_valid,
  input  logic [AW-1:0]    exc_target,
  input  logic             if_busy,
  input  logic             id_bl_nottaken,
  output logic [3:0]       stall,
  output logic             flush,
  output logic             clrslot,
  output logic             redir_valid,
  output logic [AW-1:0]    redir_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, REDIR} state_t;

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic [AW-1:0]    tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0]       stall_c;
  logic             flush_c;
  logic             clr_c;
  logic             redir_c;
  logic [AW-1:0]    rpc_c;
  logic             cnt_inc;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    stall_c = 4'b0000;
    flush_c = 1'b0;
    clr_c   = 1'b0;
    redir_c = 1'b0;
    rpc_c   = '0;
    unique case (state_q)
      RUN: begin
        if (exc_valid) begin
          flush_c = 1'b1;
          redir_c = 1'b1;
          rpc_c   = exc_target;
          tgt_d   = exc_target;
          pend_d  = 1'b0;
          if (if_busy) state_d = REDIR;
        end else begin
          if (sreq_mem)     stall_c = 4'b1111;
          else if (sreq_ex) stall_c = 4'b0111;
          else if (sreq_id) stall_c = 4'b0011;
          else if (sreq_if) stall_c = 4'b0001;
          // A held IF/ID keeps the branch in ID; it re-signals later.
          if (!stall_c[1]) begin
            clr_c = sreq_if | id_bl_nottaken | pend_q;
            if (sreq_if && id_bl_nottaken) pend_d = 1'b1;
            else if (!sreq_if)             pend_d = 1'b0;
          end
        end
      end
      REDIR: begin
        clr_c   = 1'b1;
        redir_c = 1'b1;
        rpc_c   = tgt_q;
        if (exc_valid) begin
          flush_c = 1'b1;
          rpc_c   = exc_target;
          tgt_d   = exc_target;
          pend_d  = 1'b0;
        end
        if (!if_busy) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign cnt_inc = (stall_c[0] || state_q == REDIR) && !(&cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      if (cnt_inc) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall       = rst ? 4'b0000 : stall_c;
  assign flush       = rst ? 1'b0 : flush_c;
  assign clrslot     = rst ? 1'b0 : clr_c;
  assign redir_valid = rst ? 1'b0 : redir_c;
  assign redir_pc    = rst ? '0 : rpc_c;
  assign stall_cnt   = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, exception redirect,
// branch-likely nullify, reset in REDIR and counter saturation.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sreq_if, sreq_id, sreq_ex, sreq_mem;
  logic        exc_valid;
  logic [31:0] exc_target;
  logic        if_busy;
  logic        id_bl_nottaken;

  logic [3:0]  stall;
  logic        flush, clrslot, redir_valid;
  logic [31:0] redir_pc;
  logic [31:0] stall_cnt;

  logic [3:0]  s_stall;
  logic        s_flush, s_clrslot, s_redir_valid;
  logic [31:0] s_redir_pc;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl u_dut (
    .clk(clk), .rst(rst),
    .sreq_if(sreq_if), .sreq_id(sreq_id),
    .sreq_ex(sreq_ex), .sreq_mem(sreq_mem),
    .exc_valid(exc_valid), .exc_target(exc_target),
    .if_busy(if_busy), .id_bl_nottaken(id_bl_nottaken),
    .stall(stall), .flush(flush), .clrslot(clrslot),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.AW(32), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .sreq_if(sreq_if), .sreq_id(sreq_id),
    .sreq_ex(sreq_ex), .sreq_mem(sreq_mem),
    .exc_valid(exc_valid), .exc_target(exc_target),
    .if_busy(if_busy), .id_bl_nottaken(id_bl_nottaken),
    .stall(s_stall), .flush(s_flush), .clrslot(s_clrslot),
    .redir_valid(s_redir_valid), .redir_pc(s_redir_pc),
    .stall_cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nx;
    @(negedge clk);
    rst = 1'b0; sreq_if = 1'b0; sreq_id = 1'b0;
    sreq_ex = 1'b0; sreq_mem = 1'b0; exc_valid = 1'b0;
    exc_target = '0; if_busy = 1'b0; id_bl_nottaken = 1'b0;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    nx;
    rst = 1'b1; sreq_mem = 1'b1; exc_valid = 1'b1;
    exc_target = 32'hDEAD_BEEF; settle;
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redir", redir_valid, 0);
    chk("rst_pc", redir_pc, 0);
    chk("rst_clr", clrslot, 0);
    nx; settle;
    chk("idle_stall", stall, 0);
    chk("idle_cnt", stall_cnt, 0);

    nx; sreq_ex = 1; sreq_if = 1; settle;
    chk("t1_ex_stall", stall, 4'b0111);
    chk("t1_ex_clr", clrslot, 0);
    nx; sreq_if = 1; settle;
    chk("t1_if_stall", stall, 4'b0001);
    chk("t1_if_clr", clrslot, 1);
    chk("t1_cnt", stall_cnt, 1);
    nx; sreq_mem = 1; sreq_id = 1; settle;
    chk("mem_stall", stall, 4'b1111);
    chk("mem_clr", clrslot, 0);
    nx; sreq_id = 1; settle;
    chk("id_stall", stall, 4'b0011);
    chk("id_cnt", stall_cnt, 3);
    nx; settle;
    chk("none_stall", stall, 0);
    chk("none_clr", clrslot, 0);
    chk("none_cnt", stall_cnt, 4);

    nx; exc_valid = 1; exc_target = 32'hBFC0_0380; sreq_mem = 1; settle;
    chk("t2_flush", flush, 1);
    chk("t2_stall", stall, 0);
    chk("t2_redir", redir_valid, 1);
    chk("t2_pc", redir_pc, 32'hBFC0_0380);
    nx; settle;
    chk("t2_flush_after", flush, 0);
    chk("t2_redir_after", redir_valid, 0);
    chk("t2_cnt", stall_cnt, 4);

    nx; exc_valid = 1; exc_target = 32'h8000_0180; if_busy = 1; settle;
    chk("t3_flush", flush, 1);
    chk("t3_pc0", redir_pc, 32'h8000_0180);
    nx; if_busy = 1; sreq_mem = 1; settle;
    chk("t3_r1_flush", flush, 0);
    chk("t3_r1_stall", stall, 0);
    chk("t3_r1_clr", clrslot, 1);
    chk("t3_r1_redir", redir_valid, 1);
    chk("t3_r1_pc", redir_pc, 32'h8000_0180);
    nx; if_busy = 1; settle;
    chk("t3_r2_redir", redir_valid, 1);
    chk("t3_r2_clr", clrslot, 1);
    chk("t3_r2_cnt", stall_cnt, 5);
    nx; settle;
    chk("t3_r3_redir", redir_valid, 1);
    chk("t3_r3_pc", redir_pc, 32'h8000_0180);
    chk("t3_r3_clr", clrslot, 1);
    nx; settle;
    chk("t3_run_redir", redir_valid, 0);
    chk("t3_run_clr", clrslot, 0);
    chk("t3_cnt", stall_cnt, 7);

    nx; id_bl_nottaken = 1; sreq_if = 1; settle;
    chk("t4_a_stall", stall, 4'b0001);
    nx; id_bl_nottaken = 1; sreq_if = 1; settle;
    chk("t4_b_cnt", stall_cnt, 8);
    nx; settle;
    chk("t4_nullify", clrslot, 1);
    chk("t4_nullify_stall", stall, 0);
    nx; settle;
    chk("t4_once", clrslot, 0);
    chk("t4_cnt", stall_cnt, 9);

    nx; id_bl_nottaken = 1; settle;
    chk("bl_direct", clrslot, 1);
    nx; settle;
    chk("bl_direct_after", clrslot, 0);
    nx; id_bl_nottaken = 1; sreq_id = 1; settle;
    chk("bl_held_stall", stall, 4'b0011);
    chk("bl_held_clr", clrslot, 0);
    nx; settle;
    chk("bl_held_after", clrslot, 0);
    chk("bl_held_cnt", stall_cnt, 10);

    nx; id_bl_nottaken = 1; sreq_if = 1; settle;
    nx; sreq_ex = 1; settle;
    chk("pend_ex_clr", clrslot, 0);
    nx; settle;
    chk("pend_kept", clrslot, 1);
    nx; settle;
    chk("pend_cleared", clrslot, 0);
    chk("pend_cnt", stall_cnt, 12);

    nx; id_bl_nottaken = 1; sreq_if = 1; settle;
    nx; exc_valid = 1; exc_target = 32'h0000_1234; settle;
    chk("t5_flush", flush, 1);
    chk("t5_pc", redir_pc, 32'h0000_1234);
    nx; settle;
    chk("t5_no_clr", clrslot, 0);
    chk("t5_no_redir", redir_valid, 0);
    nx; settle;
    chk("t5_no_clr2", clrslot, 0);
    chk("t5_cnt", stall_cnt, 13);

    nx; exc_valid = 1; exc_target = 32'hBFC0_0380; if_busy = 1; settle;
    nx; if_busy = 1; settle;
    chk("t6_in_redir", redir_valid, 1);
    nx; rst = 1; if_busy = 1; settle;
    chk("t6_rst_redir", redir_valid, 0);
    chk("t6_rst_clr", clrslot, 0);
    chk("t6_rst_cnt", stall_cnt, 0);
    nx; if_busy = 1; settle;
    chk("t6_run_redir", redir_valid, 0);
    chk("t6_run_clr", clrslot, 0);
    chk("t6_run_flush", flush, 0);
    chk("t6_run_stall", stall, 0);
    chk("t6_run_pc", redir_pc, 0);
    chk("t6_run_cnt", stall_cnt, 0);

    nx; sreq_if = 1;
    repeat (15) @(posedge clk);
    @(negedge clk); #1;
    chk("sat_at_max", s_cnt, 4'hF);
    chk("main_cnt15", stall_cnt, 15);
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    chk("sat_hold", s_cnt, 4'hF);
    chk("main_cnt20", stall_cnt, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
